// File: rtl/lbuf_pingpong_ctrl_if.sv
// lbuf_pingpong_ctrl_if: sprite-engine, video-scan and line-buffer RAM signals of the ping-pong controller
//   master: controller view (drives sp_ack/sp_ovf, vid_pix, bank, both RAM port controls)
//   slave : environment view (sprite engine, video timing, RAM)
interface lbuf_pingpong_ctrl_if #(
    parameter int XW = 9,
    parameter int DW = 8
);
    logic          hstart;
    logic          sp_req;
    logic [XW-1:0] sp_x;
    logic [DW-1:0] sp_pix;
    logic          sp_ack;
    logic          sp_ovf;
    logic          vid_en;
    logic [XW-1:0] vid_x;
    logic [DW-1:0] vid_pix;
    logic          bank;
    logic [XW:0]   lb0_ad;
    logic          lb0_wr;
    logic [DW-1:0] lb0_di;
    logic [XW:0]   lb1_ad;
    logic          lb1_wr;
    logic [DW-1:0] lb1_di;
    logic [DW-1:0] lb1_do;
    modport master (
        input  hstart, sp_req, sp_x, sp_pix, vid_en, vid_x, lb1_do,
        output sp_ack, sp_ovf, vid_pix, bank, lb0_ad, lb0_wr, lb0_di, lb1_ad, lb1_wr, lb1_di
    );
    modport slave (
        output hstart, sp_req, sp_x, sp_pix, vid_en, vid_x, lb1_do,
        input  sp_ack, sp_ovf, vid_pix, bank, lb0_ad, lb0_wr, lb0_di, lb1_ad, lb1_wr, lb1_di
    );
endinterface

// File: rtl/lbuf_pingpong_ctrl.sv
// lbuf_pingpong_ctrl: ping-pong sequencer for a two-half sprite line buffer
//   clk_i : clock, all logic on posedge
//   rst_i : synchronous active-high reset
//   bus   : sprite write handshake, video scan, line-buffer RAM ports (master modport)
module lbuf_pingpong_ctrl #(
    parameter int            XW     = 9,
    parameter int            DW     = 8,
    parameter logic [DW-1:0] TRANSP = '0
) (
    input logic                  clk_i,
    input logic                  rst_i,
    lbuf_pingpong_ctrl_if.master bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          bank_q, bank_d;
    logic          ack_q, ack_d;
    logic          ovf_q, ovf_d;
    logic [XW:0]   ad0_q, ad0_d;
    logic          wr0_q, wr0_d;
    logic [DW-1:0] di0_q, di0_d;
    logic [XW:0]   ad1_q, ad1_d;
    logic          wr1_q, wr1_d;
    logic          v2_q, v2_d;
    logic [DW-1:0] pix_q, pix_d;

    always_comb begin
        state_d = state_q == WRITE ? IDLE : state_q;
        bank_d  = bank_q ^ bus.hstart;
        ack_d   = 1'b0;
        ovf_d   = bus.hstart ? 1'b0 : ovf_q;
        ad0_d   = ad0_q;
        wr0_d   = 1'b0;
        di0_d   = di0_q;
        // Every ack passes through WRITE so the requester gets one cycle to present its next pixel.
        if (state_q == IDLE && bus.sp_req) begin
            state_d = WRITE;
            ack_d   = 1'b1;
            if (bus.hstart) begin
                ovf_d = 1'b1;
            end else begin
                ad0_d = {bank_q, bus.sp_x};
                di0_d = bus.sp_pix;
                wr0_d = bus.sp_pix != TRANSP;
            end
        end
        // Scan half is captured at sample time, so a read stays in its half across a swap.
        ad1_d = {~bank_q, bus.vid_x};
        wr1_d = bus.vid_en;
        v2_d  = wr1_q;
        pix_d = v2_q ? bus.lb1_do : TRANSP;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bank_q  <= 1'b0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            ad0_q   <= '0;
            wr0_q   <= 1'b0;
            di0_q   <= TRANSP;
            ad1_q   <= '0;
            wr1_q   <= 1'b0;
            v2_q    <= 1'b0;
            pix_q   <= TRANSP;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
            ad0_q   <= ad0_d;
            wr0_q   <= wr0_d;
            di0_q   <= di0_d;
            ad1_q   <= ad1_d;
            wr1_q   <= wr1_d;
            v2_q    <= v2_d;
            pix_q   <= pix_d;
        end
    end

    assign bus.sp_ack  = ack_q;
    assign bus.sp_ovf  = ovf_q;
    assign bus.bank    = bank_q;
    assign bus.lb0_ad  = ad0_q;
    assign bus.lb0_wr  = wr0_q;
    assign bus.lb0_di  = di0_q;
    assign bus.lb1_ad  = ad1_q;
    assign bus.lb1_wr  = wr1_q;
    assign bus.lb1_di  = TRANSP;
    assign bus.vid_pix = pix_q;
endmodule

// File: tb/tb_lbuf_pingpong_ctrl.sv
// tb_lbuf_pingpong_ctrl: directed and randomized checks of the ping-pong line-buffer controller
module tb_lbuf_pingpong_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;

    lbuf_pingpong_ctrl_if #(.XW(9), .DW(8)) bus();
    lbuf_pingpong_ctrl #(.XW(9), .DW(8), .TRANSP(8'h00)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    // Line-buffer RAM: read-before-write, registered port-1 output.
    logic [7:0] mem [1024] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.lb0_wr) mem[bus.lb0_ad] <= bus.lb0_di;
        if (bus.lb1_wr) mem[bus.lb1_ad] <= bus.lb1_di;
        bus.lb1_do <= mem[bus.lb1_ad];
    end

    // Reference: expected contents of each half, and the expected draw half.
    logic [7:0] mdl [2][512];
    logic       mbank;
    logic [8:0] qx[$];
    logic [7:0] qp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_bank", 32'(bus.bank), 0);
        chk("rst_ack", 32'(bus.sp_ack), 0);
        chk("rst_ovf", 32'(bus.sp_ovf), 0);
        chk("rst_lb0_wr", 32'(bus.lb0_wr), 0);
        chk("rst_lb1_wr", 32'(bus.lb1_wr), 0);
        chk("rst_lb0_ad", 32'(bus.lb0_ad), 0);
        chk("rst_lb1_ad", 32'(bus.lb1_ad), 0);
        chk("rst_lb0_di", 32'(bus.lb0_di), 0);
        chk("rst_vid_pix", 32'(bus.vid_pix), 0);
    endtask

    task automatic pulse_hstart();
        bus.hstart = 1'b1;
        step();
        bus.hstart = 1'b0;
        mbank = ~mbank;
        chk("bank_swap", 32'(bus.bank), 32'(mbank));
    endtask

    // Held-request burst from qx/qp; next pixel is presented in the cycle after each ack.
    task automatic draw();
        int n = qx.size();
        bus.sp_req = 1'b1;
        bus.sp_x = qx[0];
        bus.sp_pix = qp[0];
        for (int k = 0; k < n; k++) begin
            step();
            chk("sp_ack", 32'(bus.sp_ack), 1);
            chk("lb0_wr", 32'(bus.lb0_wr), 32'(qp[k] != 8'h00));
            chk("lb0_ad", 32'(bus.lb0_ad), 32'({mbank, qx[k]}));
            chk("lb0_di", 32'(bus.lb0_di), 32'(qp[k]));
            if (qp[k] != 8'h00) mdl[mbank][qx[k]] = qp[k];
            if (k < n - 1) begin
                bus.sp_x = qx[k+1];
                bus.sp_pix = qp[k+1];
            end else begin
                bus.sp_req = 1'b0;
            end
            step();
            chk("ack_gap", 32'(bus.sp_ack), 0);
            chk("wr_gap", 32'(bus.lb0_wr), 0);
        end
    endtask

    // Scan the qx locations back-to-back; pixel appears three cycles after sampling.
    task automatic scan();
        logic [7:0] exp_q[$];
        logic [7:0] e;
        logic       sb;
        int n = qx.size();
        for (int i = 0; i < n + 2; i++) begin
            sb = ~mbank;
            bus.vid_en = i < n;
            if (i < n) begin
                bus.vid_x = qx[i];
                e = mdl[sb][qx[i]];
                mdl[sb][qx[i]] = 8'h00;
            end else begin
                e = 8'h00;
            end
            step();
            chk("lb1_wr", 32'(bus.lb1_wr), 32'(i < n));
            if (i < n) chk("lb1_ad", 32'(bus.lb1_ad), 32'({sb, qx[i]}));
            exp_q.push_back(e);
            if (exp_q.size() == 3) chk("vid_pix", 32'(bus.vid_pix), 32'(exp_q.pop_front()));
        end
        bus.vid_en = 1'b0;
    endtask

    initial begin
        logic b;
        logic [8:0] base;
        int n;
        bus.hstart = 1'b0;
        bus.sp_req = 1'b0;
        bus.sp_x = '0;
        bus.sp_pix = '0;
        bus.vid_en = 1'b0;
        bus.vid_x = '0;
        mbank = 1'b0;
        for (int h = 0; h < 2; h++)
            for (int x = 0; x < 512; x++) mdl[h][x] = 8'h00;
        step();
        step();
        chk_reset();
        rst = 1'b0;
        // Single write, then held transparent / back-to-back pixels.
        qx = {9'd5};
        qp = {8'h3A};
        draw();
        qx = {9'd10, 9'd11, 9'd12, 9'd13};
        qp = {8'h00, 8'h44, 8'h00, 8'h45};
        draw();
        // Swap and scan, then rescan the same half a line pair later.
        pulse_hstart();
        step();
        step();
        qx = {9'd5, 9'd10, 9'd11, 9'd12, 9'd13};
        scan();
        pulse_hstart();
        pulse_hstart();
        step();
        step();
        qx = {9'd5, 9'd11};
        scan();
        // Request on the HSTART cycle is dropped with an overflow flag.
        bus.sp_req = 1'b1;
        bus.sp_x = 9'd7;
        bus.sp_pix = 8'h55;
        bus.hstart = 1'b1;
        step();
        mbank = ~mbank;
        bus.sp_req = 1'b0;
        bus.hstart = 1'b0;
        chk("ovf_bank", 32'(bus.bank), 32'(mbank));
        chk("ovf_wr", 32'(bus.lb0_wr), 0);
        chk("ovf_ack", 32'(bus.sp_ack), 1);
        chk("ovf_set", 32'(bus.sp_ovf), 1);
        step();
        chk("ovf_ack_gap", 32'(bus.sp_ack), 0);
        chk("ovf_sticky", 32'(bus.sp_ovf), 1);
        pulse_hstart();
        chk("ovf_clear", 32'(bus.sp_ovf), 0);
        // HSTART right after a write starts: write lands in the old half.
        b = mbank;
        bus.sp_req = 1'b1;
        bus.sp_x = 9'd9;
        bus.sp_pix = 8'h77;
        step();
        chk("hw_ack", 32'(bus.sp_ack), 1);
        chk("hw_wr", 32'(bus.lb0_wr), 1);
        chk("hw_ad", 32'(bus.lb0_ad), 32'({b, 9'd9}));
        mdl[b][9] = 8'h77;
        bus.sp_req = 1'b0;
        pulse_hstart();
        chk("hw_wr_end", 32'(bus.lb0_wr), 0);
        chk("hw_no_ack", 32'(bus.sp_ack), 0);
        chk("hw_no_ovf", 32'(bus.sp_ovf), 0);
        step();
        chk("hw_no_ack2", 32'(bus.sp_ack), 0);
        step();
        qx = {9'd9};
        scan();
        // Reset during a read burst flushes the pipe.
        qx = {9'd100};
        qp = {8'h5A};
        draw();
        pulse_hstart();
        step();
        step();
        bus.vid_en = 1'b1;
        bus.vid_x = 9'd100;
        step();
        mdl[~mbank][100] = 8'h00;
        bus.vid_x = 9'd101;
        rst = 1'b1;
        step();
        bus.vid_en = 1'b0;
        chk_reset();
        mbank = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_pix", 32'(bus.vid_pix), 0);
        end
        // Reset during WRITE: the in-flight write reaches RAM, outputs return to reset values.
        bus.sp_req = 1'b1;
        bus.sp_x = 9'd20;
        bus.sp_pix = 8'h66;
        step();
        chk("rw_ack", 32'(bus.sp_ack), 1);
        mdl[mbank][20] = 8'h66;
        bus.sp_req = 1'b0;
        rst = 1'b1;
        step();
        chk_reset();
        mbank = 1'b0;
        rst = 1'b0;
        step();
        // Randomized lines: draw a burst, swap, scan the drawn window.
        for (int line = 0; line < 8; line++) begin
            base = line[0] ? 9'd480 : 9'd0;
            n = $urandom_range(8, 24);
            qx.delete();
            qp.delete();
            for (int k = 0; k < n; k++) begin
                qx.push_back(base + 9'($urandom_range(0, 31)));
                qp.push_back($urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom_range(1, 255)));
            end
            draw();
            pulse_hstart();
            step();
            step();
            qx.delete();
            for (int x = 0; x < 32; x++) qx.push_back(base + 9'(x));
            scan();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
